// File: rtl/ram_nxm_sweep_pkg.sv
// Shared types for the swept NxM RAM: controller state and R_W_ encodings.
package ram_nxm_sweep_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/ram_nxm_core.sv
// Plain DEPTH x WIDTH array: synchronous write port, registered read port.
// rzero forces the read register to zero for addresses outside the array.
module ram_nxm_core #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK_,
    input  logic              CLR,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  data_out
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK_) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge CLK_ or posedge CLR) begin
        if (CLR) begin
            data_out <= '0;
        end else if (re) begin
            data_out <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/ram_nxm_sweep.sv
// Single-port RAM with registered read, range check and a hardware clear sweep
// that zeroes one word per cycle after reset or on CLR_MEM; accesses ignored while busy.
module ram_nxm_sweep
    import ram_nxm_sweep_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     CLK_,
    input  logic                     CLR,
    input  logic                     EN,
    input  logic                     R_W_,
    input  logic [$clog2(DEPTH)-1:0] ADDR_,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     CLR_MEM,
    output logic [WIDTH-1:0]         data_out,
    output logic                     rd_valid,
    output logic                     busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_V  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] sweep_ptr, ptr_nxt;
    logic              we, re, rzero, in_range;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;

    // Only reachable false when DEPTH is not a power of two.
    assign in_range = ({1'b0, ADDR_} < DEPTH_V);
    assign busy     = (state == SWEEP);

    always_ff @(posedge CLK_ or posedge CLR) begin
        if (CLR) begin
            state     <= SWEEP;
            sweep_ptr <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sweep_ptr <= ptr_nxt;
            rd_valid  <= re;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = sweep_ptr;
        we        = 1'b0;
        waddr     = ADDR_;
        wdata     = data_in;
        re        = 1'b0;
        rzero     = 1'b0;
        case (state)
            SWEEP: begin
                we    = 1'b1;
                waddr = sweep_ptr;
                wdata = '0;
                if (sweep_ptr == LAST_PTR) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = sweep_ptr + 1'b1;
                end
            end
            IDLE: begin
                // A clear request swallows any same-cycle access.
                if (CLR_MEM) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                end else if (EN) begin
                    if (R_W_ == RW_WRITE) begin
                        we = in_range;
                    end else begin
                        re    = 1'b1;
                        rzero = !in_range;
                    end
                end
            end
            default: begin
                state_nxt = SWEEP;
                ptr_nxt   = '0;
            end
        endcase
    end

    ram_nxm_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_core (
        .CLK_    (CLK_),
        .CLR     (CLR),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (re),
        .rzero   (rzero),
        .raddr   (ADDR_),
        .data_out(data_out)
    );

endmodule
